stg_hazard_ctl: RTL and testbench
=================================

// Module: stg_hazard_ctl
// PURPOSE
//  Issue scheduler for the ID->EX boundary. Tracks in-flight GP/SR writes in a
//  per-register countdown scoreboard and stalls a decoded instruction whose
//  operands are still pending. On a taken branch from EX it drives the flush of
//  the decode latch for a fixed number of cycles.
//  Sits between the decode-stage latch outputs and the IF/ID hold and flush inputs.
// PARAMETERS
//  GP_AW      4  GP register index width (2**GP_AW entries)
//  SR_AW      2  SR register index width (2**SR_AW entries)
//  WB_LAT     3  cycles from issue until the write is architecturally visible; >=2
//  FLUSH_CYC  2  cycles ow_flush is held after a taken branch; >=1
// PORTS
//  iw_clk        in   1           clock, rising edge
//  iw_rst_n      in   1           asynchronous reset, active-low
//  iw_valid      in   1           decode latch holds a real instruction
//  iw_src_gp     in   GP_AW       source GP index
//  iw_src_gp_en  in   1           source GP is read
//  iw_tgt_gp     in   GP_AW       target GP index
//  iw_tgt_gp_rd  in   1           target GP is read as an operand (CMP/ST forms)
//  iw_tgt_gp_we  in   1           target GP is written
//  iw_is_ld      in   1           instruction is a load (LDu)
//  iw_src_sr     in   SR_AW       source SR index
//  iw_src_sr_en  in   1           source SR is read (SRMOVu/SRJCCu)
//  iw_tgt_sr     in   SR_AW       target SR index
//  iw_tgt_sr_we  in   1           target SR is written
//  iw_br_taken   in   1           EX resolved a taken branch this cycle
//  ow_issue      out  1           instruction leaves ID into EX this cycle
//  ow_bubble     out  1           EX receives a NOP this cycle
//  ow_stall      out  1           hold PC and the IF/ID latches
//  ow_flush      out  1           drives iw_flush of the decode stage
//  ow_state      out  2           00 RUN, 01 STALL, 10 FLUSH
//  ow_busy_gp    out  2**GP_AW    per-GP pending bitmap (counter != 0)
// BEHAVIOUR
//  Reset: async on iw_rst_n=0. All counters and load bits cleared, state RUN,
//   flush counter 0. All outputs are 0 during reset. A pending scoreboard is
//   discarded by reset mid-operation.
//  Scoreboard: one counter (clog2(WB_LAT+1) bits) per GP and per SR, plus a
//   load bit per GP.
//   - Each cycle a nonzero counter decrements by 1.
//   - On an issue with a write enable, the target's counter loads WB_LAT and its
//     load bit loads iw_is_ld. The load overrides the decrement in the same cycle.
//  Hazard (combinational):
//   - A read GP (src if en, tgt if rd) or a read SR has counter != 0.
//   - Write-after-write is blocked the same way: a target GP/SR with counter != 0.
//  Issue: ow_issue = iw_valid & !hazard & state!=FLUSH & !iw_br_taken.
//   - Zero added latency.
//   - ow_bubble = !ow_issue.
//   - ow_stall = iw_valid & hazard & state!=FLUSH & !iw_br_taken.
//  FSM (registered):
//   - RUN -> STALL when ow_stall.
//   - STALL -> RUN when the hazard clears.
//   - Any state -> FLUSH when iw_br_taken; the flush counter loads FLUSH_CYC-1.
//   - FLUSH: ow_flush=1, no issue, counter decrements. Exits to RUN at 0.
//   - iw_br_taken during FLUSH reloads the counter.
//  Priority: br_taken > hazard > issue. Taken branch and hazard in the same cycle
//   give FLUSH; ow_stall=0.
//  Scoreboard counters keep decrementing in STALL and FLUSH. Instructions younger
//   than the branch have not issued, so no scoreboard squash is needed.
//  iw_valid=0: no issue, no stall, no scoreboard load.
// CONFIGURATION
//  HAZARD_FWD_EN defined (EX/MEM forwarding present): a GP read is blocked only if
//   the counter equals WB_LAT and the load bit is set. This is a 1-cycle load-use
//   bubble; ALU results never stall.
//   - SR hazards and GP write-after-write are unchanged.
//   - The load bit is cleared when its counter reaches 0.
//  HAZARD_FWD_EN undefined: full interlock as above. The load bit is stored but ignored.
// TESTING (WB_LAT=3, FLUSH_CYC=2)
//  1. rst_n=0 with valid=1 -> all outputs 0, busy_gp=0. Release -> RUN, and the
//     cycle-0 instruction with no hazard issues.
//  2. ADDu r3 issues at c0; MOVu src r3 valid from c1 -> stall=1 at c1..c3, issue
//     at c4. busy_gp[3] is 1 at c1..c3 and 0 at c4.
//  3. Back-to-back writes r1,r2,r4 with reads of r5,r6 -> issue every cycle, stall never asserted.
//  4. br_taken at c2 of the scenario-2 stall -> flush=1 at c2,c3, issue=0.
//     State RUN at c4; r3 issues at c4.
//  5. SRMOVu tgt sr1 at c0, SRJCCu src sr1 at c1 -> stall c1..c3, issue c4.
//     With br_taken at c4, issue=0 and flush=1.
//  6. HAZARD_FWD_EN: LDu r5 at c0, ADDu src r5 -> one bubble (c1), issue c2.
//     ADDu r5 then use -> no stall.
//     Same stimulus without the macro -> stall c1..c3.

Source files
------------

// File: rtl/stg_hazard_ctl.sv
// ID->EX issue scheduler: per-register countdown scoreboard, operand/WAW stall, branch flush.
// Optional macro HAZARD_FWD_EN: with EX/MEM forwarding only a load-use blocks GP reads.
module stg_hazard_ctl #(
    parameter int GP_AW     = 4,
    parameter int SR_AW     = 2,
    parameter int WB_LAT    = 3,
    parameter int FLUSH_CYC = 2
) (
    input  logic                    iw_clk,
    input  logic                    iw_rst_n,
    input  logic                    iw_valid,
    input  logic [GP_AW-1:0]        iw_src_gp,
    input  logic                    iw_src_gp_en,
    input  logic [GP_AW-1:0]        iw_tgt_gp,
    input  logic                    iw_tgt_gp_rd,
    input  logic                    iw_tgt_gp_we,
    input  logic                    iw_is_ld,
    input  logic [SR_AW-1:0]        iw_src_sr,
    input  logic                    iw_src_sr_en,
    input  logic [SR_AW-1:0]        iw_tgt_sr,
    input  logic                    iw_tgt_sr_we,
    input  logic                    iw_br_taken,
    output logic                    ow_issue,
    output logic                    ow_bubble,
    output logic                    ow_stall,
    output logic                    ow_flush,
    output logic [1:0]              ow_state,
    output logic [(1<<GP_AW)-1:0]   ow_busy_gp
);

    localparam int GP_N = 1 << GP_AW;
    localparam int SR_N = 1 << SR_AW;
    localparam int CW   = $clog2(WB_LAT + 1);
    localparam int FW   = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [CW-1:0] LAT     = CW'(WB_LAT);
    localparam logic [FW-1:0] FL_LOAD = FW'(FLUSH_CYC - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    state_t          r_state, w_state_next;
    logic [FW-1:0]   r_fcnt, w_fcnt_next;
    logic [GP_N-1:0] w_gp_busy, w_gp_rdblk;
    logic [SR_N-1:0] w_sr_busy;
    logic            w_hazard, w_gate, w_issue, w_stall;

    genvar gi;
    generate
        for (gi = 0; gi < GP_N; gi++) begin : g_gp
            logic [CW-1:0] r_cnt;
            logic          r_ld;
            always_ff @(posedge iw_clk or negedge iw_rst_n) begin
                if (!iw_rst_n) begin
                    r_cnt <= '0;
                    r_ld  <= 1'b0;
                end else if (w_issue && iw_tgt_gp_we && iw_tgt_gp == GP_AW'(gi)) begin
                    r_cnt <= LAT;
                    r_ld  <= iw_is_ld;
                end else begin
                    if (r_cnt != '0)
                        r_cnt <= r_cnt - CW'(1);
                    // load bit dies together with its countdown
                    r_ld <= r_ld & (r_cnt > CW'(1));
                end
            end
            assign w_gp_busy[gi] = (r_cnt != '0);
`ifdef HAZARD_FWD_EN
            assign w_gp_rdblk[gi] = r_ld & (r_cnt == LAT);
`else
            assign w_gp_rdblk[gi] = (r_cnt != '0);
`endif
        end

        for (gi = 0; gi < SR_N; gi++) begin : g_sr
            logic [CW-1:0] r_cnt;
            always_ff @(posedge iw_clk or negedge iw_rst_n) begin
                if (!iw_rst_n)
                    r_cnt <= '0;
                else if (w_issue && iw_tgt_sr_we && iw_tgt_sr == SR_AW'(gi))
                    r_cnt <= LAT;
                else if (r_cnt != '0)
                    r_cnt <= r_cnt - CW'(1);
            end
            assign w_sr_busy[gi] = (r_cnt != '0);
        end
    endgenerate

    assign w_hazard = (iw_src_gp_en & w_gp_rdblk[iw_src_gp])
                    | (iw_tgt_gp_rd & w_gp_rdblk[iw_tgt_gp])
                    | (iw_tgt_gp_we & w_gp_busy[iw_tgt_gp])
                    | (iw_src_sr_en & w_sr_busy[iw_src_sr])
                    | (iw_tgt_sr_we & w_sr_busy[iw_tgt_sr]);

    // reset gates the combinational outputs so everything reads 0 while held
    assign w_gate  = iw_rst_n & iw_valid & (r_state != ST_FLUSH) & ~iw_br_taken;
    assign w_issue = w_gate & ~w_hazard;
    assign w_stall = w_gate & w_hazard;

    always_comb begin
        w_state_next = r_state;
        w_fcnt_next  = r_fcnt;
        if (iw_br_taken) begin
            w_state_next = ST_FLUSH;
            w_fcnt_next  = FL_LOAD;
        end else begin
            case (r_state)
                ST_RUN:   if (w_stall) w_state_next = ST_STALL;
                ST_STALL: if (!(iw_valid && w_hazard)) w_state_next = ST_RUN;
                ST_FLUSH: begin
                    if (r_fcnt <= FW'(1)) begin
                        w_state_next = ST_RUN;
                        w_fcnt_next  = '0;
                    end else begin
                        w_fcnt_next = r_fcnt - FW'(1);
                    end
                end
                default:  w_state_next = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            r_state <= ST_RUN;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_fcnt  <= w_fcnt_next;
        end
    end

    assign ow_issue   = w_issue;
    assign ow_stall   = w_stall;
    assign ow_bubble  = iw_rst_n & ~w_issue;
    assign ow_flush   = iw_rst_n & ((r_state == ST_FLUSH) | iw_br_taken);
    assign ow_state   = r_state;
    assign ow_busy_gp = w_gp_busy;

endmodule

// File: tb/tb_stg_hazard_ctl.sv
// Bench for stg_hazard_ctl: directed scenarios plus random traffic against a ready-cycle model.
module tb_stg_hazard_ctl;
    localparam int GP_AW = 4, SR_AW = 2, WB_LAT = 3, FLUSH_CYC = 2;
    localparam int GP_N = 1 << GP_AW, SR_N = 1 << SR_AW;

    logic clk = 1'b0, rst_n = 1'b0;
    logic valid = 1'b0, src_gp_en = 1'b0, tgt_gp_rd = 1'b0, tgt_gp_we = 1'b0, is_ld = 1'b0;
    logic src_sr_en = 1'b0, tgt_sr_we = 1'b0, br_taken = 1'b0;
    logic [GP_AW-1:0] src_gp = '0, tgt_gp = '0;
    logic [SR_AW-1:0] src_sr = '0, tgt_sr = '0;
    logic o_issue, o_bubble, o_stall, o_flush;
    logic [1:0] o_state;
    logic [GP_N-1:0] o_busy;

    always #5 clk = ~clk;

    stg_hazard_ctl #(.GP_AW(GP_AW), .SR_AW(SR_AW), .WB_LAT(WB_LAT), .FLUSH_CYC(FLUSH_CYC)) dut (
        .iw_clk(clk), .iw_rst_n(rst_n), .iw_valid(valid),
        .iw_src_gp(src_gp), .iw_src_gp_en(src_gp_en),
        .iw_tgt_gp(tgt_gp), .iw_tgt_gp_rd(tgt_gp_rd), .iw_tgt_gp_we(tgt_gp_we),
        .iw_is_ld(is_ld), .iw_src_sr(src_sr), .iw_src_sr_en(src_sr_en),
        .iw_tgt_sr(tgt_sr), .iw_tgt_sr_we(tgt_sr_we), .iw_br_taken(br_taken),
        .ow_issue(o_issue), .ow_bubble(o_bubble), .ow_stall(o_stall), .ow_flush(o_flush),
        .ow_state(o_state), .ow_busy_gp(o_busy)
    );

    int n_vec = 0, n_err = 0;
    // reference model: each register is busy until a "ready" cycle number
    int cyc, last_br;
    int gp_ready[GP_N], gp_iss[GP_N], sr_ready[SR_N];
    bit gp_ld[GP_N];
    bit prev_stall;
    bit e_issue, e_stall, e_flush;
    logic [1:0] e_state;
    logic [GP_N-1:0] e_busy;
    bit s_issue, s_stall, s_flush;
    logic [1:0] s_state;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0; last_br = -100; prev_stall = 1'b0;
        for (int r = 0; r < GP_N; r++) begin gp_ready[r] = 0; gp_iss[r] = -100; gp_ld[r] = 1'b0; end
        for (int r = 0; r < SR_N; r++) sr_ready[r] = 0;
    endtask

    function automatic bit gp_busy(int r);
        return cyc < gp_ready[r];
    endfunction

    function automatic bit gp_rdblk(int r);
`ifdef HAZARD_FWD_EN
        return gp_ld[r] && (cyc == gp_iss[r] + 1);
`else
        return cyc < gp_ready[r];
`endif
    endfunction

    task automatic model_eval();
        bit haz, in_fl;
        haz = (src_gp_en && gp_rdblk(int'(src_gp))) || (tgt_gp_rd && gp_rdblk(int'(tgt_gp)))
           || (tgt_gp_we && gp_busy(int'(tgt_gp)))
           || (src_sr_en && cyc < sr_ready[src_sr]) || (tgt_sr_we && cyc < sr_ready[tgt_sr]);
        in_fl   = (cyc - last_br >= 1) && (cyc - last_br <= FLUSH_CYC - 1);
        e_issue = valid && !haz && !in_fl && !br_taken;
        e_stall = valid && haz && !in_fl && !br_taken;
        e_flush = in_fl || br_taken;
        e_state = in_fl ? 2'b10 : (prev_stall ? 2'b01 : 2'b00);
        for (int r = 0; r < GP_N; r++) e_busy[r] = gp_busy(r);
    endtask

    task automatic model_commit();
        if (e_issue && tgt_gp_we) begin
            gp_ready[tgt_gp] = cyc + WB_LAT + 1;
            gp_iss[tgt_gp]   = cyc;
            gp_ld[tgt_gp]    = is_ld;
        end
        if (e_issue && tgt_sr_we) sr_ready[tgt_sr] = cyc + WB_LAT + 1;
        if (br_taken) last_br = cyc;
        prev_stall = e_stall;
        cyc++;
    endtask

    // one clock cycle: predict, sample at negedge, compare, commit at posedge
    task automatic step();
        model_eval();
        @(negedge clk);
        s_issue = o_issue; s_stall = o_stall; s_flush = o_flush; s_state = o_state;
        chk("issue", 32'(o_issue), 32'(e_issue));
        chk("bubble", 32'(o_bubble), 32'(!e_issue));
        chk("stall", 32'(o_stall), 32'(e_stall));
        chk("flush", 32'(o_flush), 32'(e_flush));
        chk("state", 32'(o_state), 32'(e_state));
        chk("busy_gp", 32'(o_busy), 32'(e_busy));
        $display("cyc=%0d v=%0b br=%0b issue=%0b stall=%0b flush=%0b state=%0d busy=%04h",
                 cyc, valid, br_taken, o_issue, o_stall, o_flush, o_state, o_busy);
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic set_ins(input bit v, input int sg, input bit sge, input int tg, input bit trd,
                           input bit twe, input bit ld, input int ss, input bit sse,
                           input int ts, input bit tse, input bit br);
        valid = v; src_gp = GP_AW'(sg); src_gp_en = sge; tgt_gp = GP_AW'(tg);
        tgt_gp_rd = trd; tgt_gp_we = twe; is_ld = ld; src_sr = SR_AW'(ss);
        src_sr_en = sse; tgt_sr = SR_AW'(ts); tgt_sr_we = tse; br_taken = br;
    endtask

    task automatic idle(input int n);
        set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_issue"}, 32'(o_issue), 32'd0);
        chk({tag, "_bubble"}, 32'(o_bubble), 32'd0);
        chk({tag, "_stall"}, 32'(o_stall), 32'd0);
        chk({tag, "_flush"}, 32'(o_flush), 32'd0);
        chk({tag, "_state"}, 32'(o_state), 32'd0);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    endtask

    task automatic rand_ins();
        set_ins($urandom_range(0, 9) < 8, int'($urandom_range(0, 7)), 1'($urandom),
                int'($urandom_range(0, 7)), $urandom_range(0, 3) == 0, 1'($urandom),
                $urandom_range(0, 2) == 0, int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
                int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
    endtask

    initial begin
        int n_st, n_fl, n_is;
        cyc = 0;
        // 1: reset held with a valid instruction present
        set_ins(1, 7, 1, 8, 0, 1, 0, 0, 0, 0, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        set_ins(1, 7, 1, 8, 0, 1, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        model_reset();
        step();
        chk("c0_issue", 32'(s_issue), 32'd1);
        idle(WB_LAT + 1);

        // 2: ADDu r3 then MOVu src r3 stalls WB_LAT cycles
        set_ins(1, 1, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
        step();
        set_ins(1, 3, 1, 9, 0, 1, 0, 0, 0, 0, 0, 0);
        n_st = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (s_issue) break;
            n_st += int'(s_stall);
        end
        chk("s2_stall_cycles", 32'(n_st), 32'(WB_LAT));
        idle(WB_LAT + 1);

        // 3: independent back-to-back writes issue every cycle
        n_is = 0; n_st = 0;
        set_ins(1, 5, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0); step(); n_is += int'(s_issue); n_st += int'(s_stall);
        set_ins(1, 6, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0); step(); n_is += int'(s_issue); n_st += int'(s_stall);
        set_ins(1, 5, 1, 4, 0, 1, 0, 0, 0, 0, 0, 0); step(); n_is += int'(s_issue); n_st += int'(s_stall);
        chk("s3_issues", 32'(n_is), 32'd3);
        chk("s3_stalls", 32'(n_st), 32'd0);
        idle(WB_LAT + 1);

        // 4: taken branch at c2 of the stall
        set_ins(1, 1, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0); step();
        set_ins(1, 3, 1, 9, 0, 1, 0, 0, 0, 0, 0, 0); step();
        n_fl = 0;
        br_taken = 1'b1; step(); n_fl += int'(s_flush && !s_issue);
        br_taken = 1'b0; step(); n_fl += int'(s_flush && !s_issue);
        chk("s4_flush_cycles", 32'(n_fl), 32'd2);
        step();
        chk("s4_c4_state", 32'(s_state), 32'd0);
        chk("s4_c4_issue", 32'(s_issue), 32'd1);
        idle(WB_LAT + 1);

        // 5: SR dependency, then branch on the would-be issue cycle
        set_ins(1, 2, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0); step();
        set_ins(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        n_st = 0;
        for (int k = 0; k < WB_LAT; k++) begin step(); n_st += int'(s_stall); end
        chk("s5_stall_cycles", 32'(n_st), 32'(WB_LAT));
        br_taken = 1'b1; step();
        chk("s5_br_issue", 32'(s_issue), 32'd0);
        chk("s5_br_flush", 32'(s_flush), 32'd1);
        idle(WB_LAT + 1);

        // 6: load-use, then ALU-use
        set_ins(1, 1, 1, 5, 0, 1, 1, 0, 0, 0, 0, 0); step();
        set_ins(1, 5, 1, 10, 0, 1, 0, 0, 0, 0, 0, 0);
        n_st = 0;
        for (int k = 0; k < 10; k++) begin step(); if (s_issue) break; n_st += int'(s_stall); end
`ifdef HAZARD_FWD_EN
        chk("s6_ld_use", 32'(n_st), 32'd1);
`else
        chk("s6_ld_use", 32'(n_st), 32'(WB_LAT));
`endif
        idle(WB_LAT + 1);
        set_ins(1, 1, 1, 5, 0, 1, 0, 0, 0, 0, 0, 0); step();
        set_ins(1, 5, 1, 11, 0, 1, 0, 0, 0, 0, 0, 0);
        n_st = 0;
        for (int k = 0; k < 10; k++) begin step(); if (s_issue) break; n_st += int'(s_stall); end
`ifdef HAZARD_FWD_EN
        chk("s6_alu_use", 32'(n_st), 32'd0);
`else
        chk("s6_alu_use", 32'(n_st), 32'(WB_LAT));
`endif

        // random traffic
        for (int k = 0; k < 400; k++) begin rand_ins(); step(); end

        // reset mid-operation discards the pending scoreboard
        set_ins(1, 0, 0, 6, 0, 1, 0, 0, 0, 2, 1, 0); step();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 150; k++) begin rand_ins(); step(); end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
